// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares the data memory's second read port and its write port
// between the load/store unit (port 0) and a debug/loader master (port 1).
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [2:0]        mode0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              ack0,
    output logic [31:0]       rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [2:0]        mode1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              ack1,
    output logic [31:0]       rdata1,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [2:0]        mem_wm,
    output logic [31:0]       mem_wd,
    output logic [ADDR_W-1:0] mem_ra,
    output logic [2:0]        mem_rm,
    input  logic [31:0]       mem_rd
);

    localparam int unsigned       HOLD_W   = 8;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic              prio_q, prio_d;
    logic              owner_vld_q, owner_vld_d;
    logic              owner_id_q, owner_id_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;

    logic both_req_c;
    logic req_any_c;
    logic own_vld_c;
    logic gnt_id_c;
    logic forced_c;
    logic sel_we_c;
    logic sel_lock_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            owner_vld_q <= 1'b0;
            owner_id_q  <= 1'b0;
            hold_cnt_q  <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            prio_q      <= prio_d;
            owner_vld_q <= owner_vld_d;
            owner_id_q  <= owner_id_d;
            hold_cnt_q  <= hold_cnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // Grant selection; an owner whose lock has dropped no longer counts this cycle
    always_comb begin
        both_req_c = req0 && req1;
        req_any_c  = req0 || req1;
        own_vld_c  = owner_vld_q && (owner_id_q ? lock1 : lock0);
        gnt_id_c   = req1;
        forced_c   = 1'b0;
        if (both_req_c) begin
            if (own_vld_c) begin
                if (hold_cnt_q >= HOLD_MAX) begin
                    gnt_id_c = ~owner_id_q;
                    forced_c = 1'b1;
                end else begin
                    gnt_id_c = owner_id_q;
                end
            end else begin
                gnt_id_c = prio_q;
            end
        end
    end

    // Outputs: grants and memory drive are gated by reset so nothing reaches memory in reset
    always_comb begin
        gnt0   = rst_n && req_any_c && !gnt_id_c;
        gnt1   = rst_n && req_any_c && gnt_id_c;
        mem_we = gnt1 ? we1 : (gnt0 && we0);
        mem_ra = gnt1 ? addr1 : addr0;
        mem_rm = gnt1 ? mode1 : mode0;
        mem_wa = gnt1 ? addr1 : addr0;
        mem_wm = gnt1 ? mode1 : mode0;
        mem_wd = gnt1 ? wdata1 : wdata0;
        ack0   = ack0_q;
        ack1   = ack1_q;
        rdata0 = rdata0_q;
        rdata1 = rdata1_q;
    end

    // Next state: priority, ownership, hold counter, ack and read-data capture
    always_comb begin
        prio_d      = prio_q;
        owner_vld_d = own_vld_c;
        owner_id_d  = owner_id_q;
        hold_cnt_d  = own_vld_c ? hold_cnt_q : '0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        sel_we_c    = gnt_id_c ? we1 : we0;
        sel_lock_c  = gnt_id_c ? lock1 : lock0;
        if (req_any_c) begin
            prio_d = ~gnt_id_c;
            if (gnt_id_c) begin
                ack1_d = 1'b1;
                if (!sel_we_c) rdata1_d = mem_rd;
            end else begin
                ack0_d = 1'b1;
                if (!sel_we_c) rdata0_d = mem_rd;
            end
            if (forced_c) begin
                hold_cnt_d = '0;
            end else if (own_vld_c && (gnt_id_c == owner_id_q)) begin
                if (both_req_c && (hold_cnt_q < HOLD_MAX)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else if (sel_lock_c) begin
                owner_vld_d = 1'b1;
                owner_id_d  = gnt_id_c;
                hold_cnt_d  = '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural data memory behind the shared ports.
module tb_mem_arbiter;

    localparam int unsigned AW = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [2:0]    mode0, mode1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [31:0]   rdata0, rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_wa, mem_ra;
    logic [2:0]    mem_wm, mem_rm;
    logic [31:0]   mem_wd, mem_rd;

    logic [31:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          c;
        bit          rd;
        logic [31:0] d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    mem_arbiter #(.ADDR_W(AW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .mode0(mode0), .wdata0(wdata0),
        .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .mode1(mode1), .wdata1(wdata1),
        .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wm(mem_wm), .mem_wd(mem_wd),
        .mem_ra(mem_ra), .mem_rm(mem_rm), .mem_rd(mem_rd)
    );

    function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [2:0] m);
        case (m)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign mem_rd = rd_fmt(mem[mem_ra], mem_rm);

    // Memory ignores invalid write modes
    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_wm)
                3'b000:  mem[mem_wa][7:0]  <= mem_wd[7:0];
                3'b001:  mem[mem_wa][15:0] <= mem_wd[15:0];
                3'b010:  mem[mem_wa]       <= mem_wd;
                default: ;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input logic rq, input logic w, input logic lk,
                            input logic [AW-1:0] a, input logic [2:0] m, input logic [31:0] d);
        if (p == 0) begin
            req0 = rq; we0 = w; lock0 = lk; addr0 = a; mode0 = m; wdata0 = d;
        end else begin
            req1 = rq; we1 = w; lock1 = lk; addr1 = a; mode1 = m; wdata1 = d;
        end
    endtask

    task automatic push(input int p, input bit rd, input logic [31:0] d);
        exp_t e;
        e.c  = cyc + 1;
        e.rd = rd;
        e.d  = d;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic single(input int p, input logic w, input logic [AW-1:0] a, input logic [2:0] m,
                          input logic [31:0] d, input logic [31:0] exp_rd, input string nm);
        @(posedge clk); #1;
        set_port(p, 1'b1, w, 1'b0, a, m, d);
        @(negedge clk);
        chk({nm, "_gnt"}, 32'({gnt1, gnt0}), (p == 0) ? 32'd1 : 32'd2);
        chk({nm, "_mem_we"}, 32'(mem_we), 32'(w));
        push(p, !w, exp_rd);
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);
    endtask

    // Monitor: every ack must match the oldest expected response at the right cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (q0.size() > 0 && q0[0].c < cyc) begin
                total++; bad++;
                $display("FAIL ack0_missing: no ack0 at cycle %0d, expected at %0d", cyc, q0[0].c);
                void'(q0.pop_front());
            end
            if (q1.size() > 0 && q1[0].c < cyc) begin
                total++; bad++;
                $display("FAIL ack1_missing: no ack1 at cycle %0d, expected at %0d", cyc, q1[0].c);
                void'(q1.pop_front());
            end
            if (ack0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack0_unexpected: ack0=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("ack0_cycle", 32'(cyc), 32'(e.c));
                    if (e.rd) chk("rdata0", rdata0, e.d);
                end
            end
            if (ack1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack1_unexpected: ack1=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("ack1_cycle", 32'(cyc), 32'(e.c));
                    if (e.rd) chk("rdata1", rdata1, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [12:0] lock_pat;
        logic [31:0] v10, v20;
        bit          g;
        lock_pat = 13'b1111101111011;
        v10 = 32'h123456AB;
        v20 = 32'h00008001;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        set_port(0, 1'b1, 1'b1, 1'b0, 9'h010, 3'b010, 32'hFFFFFFFF);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);

        // Reset state with a request pending: nothing granted or written
        @(negedge clk);
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_acks", 32'({ack1, ack0}), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        set_port(0, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        single(0, 1'b1, 9'h010, 3'b010, 32'h12345678, '0, "wr_word");
        single(0, 1'b0, 9'h010, 3'b010, '0, 32'h12345678, "rd_word");
        single(0, 1'b1, 9'h010, 3'b000, 32'h000000AB, '0, "wr_byte");
        single(0, 1'b0, 9'h010, 3'b000, '0, 32'hFFFFFFAB, "rd_sbyte");
        single(0, 1'b0, 9'h010, 3'b100, '0, 32'h000000AB, "rd_ubyte");
        single(1, 1'b1, 9'h020, 3'b001, 32'h00008001, '0, "wr_half");
        single(1, 1'b0, 9'h020, 3'b001, '0, 32'hFFFF8001, "rd_shalf");
        single(1, 1'b0, 9'h020, 3'b101, '0, 32'h00008001, "rd_uhalf");
        single(1, 1'b1, 9'h020, 3'b011, 32'hDEADBEEF, '0, "wr_badmode");
        single(1, 1'b0, 9'h020, 3'b010, '0, 32'h00008001, "rd_after_bad");

        // Back-to-back write then read of the same word
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 1'b0, 9'h030, 3'b010, 32'hCAFEF00D);
        @(negedge clk);
        chk("raw_wr_gnt", 32'({gnt1, gnt0}), 32'd1);
        push(0, 1'b0, '0);
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 1'b0, 9'h030, 3'b010, '0);
        @(negedge clk);
        chk("raw_rd_gnt", 32'({gnt1, gnt0}), 32'd1);
        push(0, 1'b1, 32'hCAFEF00D);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);

        // Lock burst by port 1 against continuous port 0 traffic (prio is at port 1 here)
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 1'b0, 9'h010, 3'b010, '0);
        set_port(1, 1'b1, 1'b0, 1'b1, 9'h020, 3'b010, '0);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            g = lock_pat[12-i];
            chk($sformatf("lock_gnt%0d", i), 32'({gnt1, gnt0}), g ? 32'd2 : 32'd1);
            push(g ? 1 : 0, 1'b1, g ? v20 : v10);
            @(posedge clk); #1;
        end
        chk("hold_cnt_mid", 32'(dut.hold_cnt_q), 32'd2);

        // Lock dropped: ownership released and round robin resumes at once
        lock1 = 1'b0;
        @(negedge clk);
        chk("unlock_gnt", 32'({gnt1, gnt0}), 32'd1);
        push(0, 1'b1, v10);
        @(posedge clk); #1;
        chk("unlock_hold", 32'(dut.hold_cnt_q), 32'd0);
        chk("unlock_owner", 32'(dut.owner_vld_q), 32'd0);
        @(negedge clk);
        chk("unlock_rr_gnt", 32'({gnt1, gnt0}), 32'd2);
        push(1, 1'b1, v20);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);

        // Reset hits while port 1 has an ack pending and a write presented
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b0, 1'b0, 9'h010, 3'b010, '0);
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b1, 1'b0, 9'h040, 3'b010, 32'h11111111);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_ack1", 32'(ack1), 32'd0);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ack1", 32'(ack1), 32'd0);
        chk("postrst_rdata1", rdata1, 32'd0);
        chk("postrst_rdata0", rdata0, 32'd0);
        chk("postrst_mem", mem[9'h040], 32'd0);

        // Both ports without lock: strict alternation starting at port 0
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 1'b0, 9'h010, 3'b010, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 9'h020, 3'b010, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", i), 32'({gnt1, gnt0}), (i % 2 == 0) ? 32'd1 : 32'd2);
            push(i % 2, 1'b1, (i % 2 == 0) ? v10 : v20);
            @(posedge clk); #1;
        end
        set_port(0, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, 3'b010, '0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the data memory's second read port (`ra2/rm2/rd2`) and its single write port (`we/wa3/wm3/wd3`) between the CPU load/store unit (port 0) and a debug/loader master (port 1).
- It grants at most one access per cycle and drives the memory ports combinationally for the granted requester.
- It returns a registered acknowledge and read data one cycle later.
- A lock mechanism gives a requester back-to-back grants for bursts, bounded by a fairness limit.

## Interface
Parameters:
- `ADDR_W`, 9, word address width; matches memory `ra*/wa3`.
- `MAX_HOLD`, 8, maximum consecutive grants to a lock owner while the other port is requesting. Range 1..255.

Ports (N ∈ {0,1}; each `*N` line describes both port instances):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN`  in  1  access request; held together with its fields until `gntN`.
- `weN`  in  1  1 = write, 0 = read.
- `lockN`  in  1  request ownership for a burst; sampled with `reqN`.
- `addrN`  in  ADDR_W  word address.
- `modeN`  in  3  access mode: 000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
- `wdataN`  in  32  write data.
- `gntN`  out  1  combinational; access performed this cycle.
- `ackN`  out  1  registered; one-cycle pulse, cycle after `gntN`.
- `rdataN`  out  32  registered read data, valid with `ackN` on reads.
- `mem_we`  out  1  to memory `we`.
- `mem_wa`  out  ADDR_W  to memory `wa3`.
- `mem_wm`  out  3  to memory `wm3`.
- `mem_wd`  out  32  to memory `wd3`.
- `mem_ra`  out  ADDR_W  to memory `ra2`.
- `mem_rm`  out  3  to memory `rm2`.
- `mem_rd`  in  32  from memory `rd2`; combinational read.

## Operation
- State:
  - `prio`: round-robin pointer, 1 bit.
  - `owner`: none, 0 or 1.
  - `hold_cnt`: 8 bits.
  - `ack`/`rdata` registers per port.
- Grant selection, evaluated each cycle. `gnt0` and `gnt1` are never both high.
  - Only one port requesting: that port is granted.
  - Both requesting, no owner: grant port `prio`.
  - Both requesting, owner = K, `hold_cnt` < MAX_HOLD: grant K.
  - Both requesting, owner = K, `hold_cnt` = MAX_HOLD: grant the other port (forced fairness grant).
- Memory drive for granted port G:
  - `mem_ra` = `addrG`, `mem_rm` = `modeG`.
  - `mem_wa` = `addrG`, `mem_wm` = `modeG`, `mem_wd` = `wdataG`.
  - `mem_we` = `weG`.
  - No grant: `mem_we` = 0; address, mode and data drive port 0 fields (don't-care).
- On each grant to G, at the clock edge:
  - `prio` ← other port.
  - `ackG` ← 1; other ack ← 0.
  - Read: `rdataG` ← `mem_rd`. Write: `rdataG` unchanged.
- No grant: both acks ← 0.
- Lock and ownership:
  - Grant to G with `lockG` = 1: owner ← G.
  - Owner K with `lockK` = 0 in any cycle: owner ← none and `hold_cnt` ← 0. This check is evaluated before the grant logic in the same cycle.
- Hold counter:
  - Grant to the owner while the other port requests: `hold_cnt` increments, saturating at MAX_HOLD.
  - Forced grant to the non-owner: `hold_cnt` ← 0; owner is retained.
  - Grant to the owner with the other port idle: `hold_cnt` unchanged.
- Invalid write modes (011, 1xx) are passed through and acknowledged; the memory ignores them.

## Timing
- Reset values:
  - `gnt0/gnt1` = 0 and `mem_we` = 0 while `rst_n` = 0 (combinationally gated).
  - `ack0/ack1` = 0, `rdata0/rdata1` = 0.
  - `prio` = 0, owner = none, `hold_cnt` = 0.
- Latency:
  - Grant in cycle t; the write commits at the end of cycle t.
  - `ackG` and `rdataG` are valid in cycle t+1.
- Throughput: one access per cycle. A requester may present its next request in t+1, overlapping its ack.
- Read-after-write: a read granted in t+1 to a word written in t returns the new data.
- Reset asserted mid-access: the grant and `mem_we` drop immediately, the pending ack is cleared, and no write is performed in that cycle.
- `req` dropped before grant: allowed; nothing is performed and no ack is issued.

## Test plan
- Reset, then port 0 writes word 0x12345678 to 0x010 and reads it back with mode 010:
  - `gnt0` is high the same cycle as each request.
  - `ack0` pulses at t+1.
  - `rdata0` = 0x12345678.
- Byte write 0xAB (mode 000) to a word holding 0x12345678, then reads:
  - Mode 000 gives `rdata` = 0xFFFFFFAB.
  - Mode 100 gives `rdata` = 0x000000AB.
- Both ports request continuously with no lock: grants alternate 0,1,0,1…, first grant to port 0; both acks follow with 1-cycle lag.
- Port 1 holds `lock1` = 1 with MAX_HOLD = 4 while port 0 requests continuously: grant pattern is 1,1,1,1,1,0,1,1,1,1,0. The first grant is port 1 by priority and makes port 1 owner; every later fifth grant goes to port 0.
- Drop `lock1` mid-burst: owner clears that cycle, the same cycle's grant follows round-robin, and `hold_cnt` reads 0.
- Assert `rst_n` = 0 in a cycle where port 1 issues a write: `mem_we` = 0, the target word is unchanged, and after release `ack1` = 0 and arbitration starts at port 0.
